// File: rtl/jtag_tap_ctrl.sv
// TAP controller for the s9234 test wrapper: 16-state TMS-driven FSM, 2-bit
// instruction register, per-chain DR enables and TDO multiplexing.
module jtag_tap_ctrl #(
    parameter logic [1:0] IR_RESET   = 2'b10,
    parameter logic [1:0] IR_CAPTURE = 2'b01
) (
    input  logic       TCLK,
    input  logic       TRST,
    input  logic       TMS,
    input  logic       TDI,
    input  logic       TDO_BSR,
    input  logic       TDO_ISR,
    output logic       TDO,
    output logic       TDO_EN,
    output logic [1:0] inst,
    output logic       test_mode,
    output logic       clockdr,
    output logic       shiftdr,
    output logic       updatedr,
    output logic       clockdr_is,
    output logic       shiftdr_is,
    output logic       updatedr_is,
    output logic [3:0] tap_state
);

    typedef enum logic [3:0] {
        TLR   = 4'd0,  RTI   = 4'd1,
        SELDR = 4'd2,  CAPDR = 4'd3,  SHDR  = 4'd4,  EX1DR = 4'd5,
        PAUDR = 4'd6,  EX2DR = 4'd7,  UPDDR = 4'd8,
        SELIR = 4'd9,  CAPIR = 4'd10, SHIR  = 4'd11, EX1IR = 4'd12,
        PAUIR = 4'd13, EX2IR = 4'd14, UPDIR = 4'd15
    } tap_state_e;

    tap_state_e state_q, state_d;
    logic [1:0] ir_stage_q, ir_stage_d;
    logic [1:0] inst_q, inst_d;
    logic       bypass_q, bypass_d;
    logic       bsr_sel_s, isr_sel_s;

    // FSM state register
    always_ff @(posedge TCLK) begin
        if (TRST) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // TAP next-state decode from TMS
    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:   state_d = TMS ? TLR   : RTI;
            RTI:   state_d = TMS ? SELDR : RTI;
            SELDR: state_d = TMS ? SELIR : CAPDR;
            CAPDR: state_d = TMS ? EX1DR : SHDR;
            SHDR:  state_d = TMS ? EX1DR : SHDR;
            EX1DR: state_d = TMS ? UPDDR : PAUDR;
            PAUDR: state_d = TMS ? EX2DR : PAUDR;
            EX2DR: state_d = TMS ? UPDDR : SHDR;
            UPDDR: state_d = TMS ? SELDR : RTI;
            SELIR: state_d = TMS ? TLR   : CAPIR;
            CAPIR: state_d = TMS ? EX1IR : SHIR;
            SHIR:  state_d = TMS ? EX1IR : SHIR;
            EX1IR: state_d = TMS ? UPDIR : PAUIR;
            PAUIR: state_d = TMS ? EX2IR : PAUIR;
            EX2IR: state_d = TMS ? UPDIR : SHIR;
            UPDIR: state_d = TMS ? SELDR : RTI;
            default: state_d = TLR;
        endcase
    end

    // Instruction, IR shift stage and bypass registers
    always_ff @(posedge TCLK) begin
        if (TRST) begin
            ir_stage_q <= 2'b00;
            inst_q     <= IR_RESET;
            bypass_q   <= 1'b0;
        end else begin
            ir_stage_q <= ir_stage_d;
            inst_q     <= inst_d;
            bypass_q   <= bypass_d;
        end
    end

    // Register updates; inst only moves in TLR and UpdIR so the chain select
    // stays fixed across an entire DR scan
    always_comb begin
        ir_stage_d = ir_stage_q;
        inst_d     = inst_q;
        bypass_d   = bypass_q;
        case (state_q)
            TLR:   inst_d     = IR_RESET;
            CAPIR: ir_stage_d = IR_CAPTURE;
            SHIR:  ir_stage_d = {TDI, ir_stage_q[1]};
            UPDIR: inst_d     = ir_stage_q;
            CAPDR: bypass_d   = 1'b0;
            SHDR:  bypass_d   = TDI;
            default: begin
                ir_stage_d = ir_stage_q;
            end
        endcase
    end

    assign bsr_sel_s = ~inst_q[1];
    assign isr_sel_s = (inst_q == 2'b11);

    assign clockdr     = bsr_sel_s & ((state_q == CAPDR) | (state_q == SHDR));
    assign shiftdr     = bsr_sel_s & (state_q == SHDR);
    assign updatedr    = bsr_sel_s & (state_q == UPDDR);
    assign clockdr_is  = isr_sel_s & ((state_q == CAPDR) | (state_q == SHDR));
    assign shiftdr_is  = isr_sel_s & (state_q == SHDR);
    assign updatedr_is = isr_sel_s & (state_q == UPDDR);

    assign TDO_EN    = (state_q == SHDR) | (state_q == SHIR);
    assign inst      = inst_q;
    assign test_mode = (inst_q == 2'b00) | (inst_q == 2'b11);
    assign tap_state = state_q;

    // Serial output mux
    always_comb begin
        TDO = 1'b0;
        if (state_q == SHIR) begin
            TDO = ir_stage_q[0];
        end else if (state_q == SHDR) begin
            if (isr_sel_s) begin
                TDO = TDO_ISR;
            end else if (bsr_sel_s) begin
                TDO = TDO_BSR;
            end else begin
                TDO = bypass_q;
            end
        end else begin
            TDO = 1'b0;
        end
    end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: expectations are queued per step and
// popped/compared once the clock edge has been taken.
module tb_jtag_tap_ctrl;

    logic       TCLK = 1'b0;
    logic       TRST = 1'b0;
    logic       TMS = 1'b0;
    logic       TDI = 1'b0;
    logic       TDO_BSR = 1'b0;
    logic       TDO_ISR = 1'b0;
    logic       TDO, TDO_EN, test_mode;
    logic [1:0] inst;
    logic       clockdr, shiftdr, updatedr, clockdr_is, shiftdr_is, updatedr_is;
    logic [3:0] tap_state;

    jtag_tap_ctrl dut (
        .TCLK(TCLK), .TRST(TRST), .TMS(TMS), .TDI(TDI),
        .TDO_BSR(TDO_BSR), .TDO_ISR(TDO_ISR),
        .TDO(TDO), .TDO_EN(TDO_EN), .inst(inst), .test_mode(test_mode),
        .clockdr(clockdr), .shiftdr(shiftdr), .updatedr(updatedr),
        .clockdr_is(clockdr_is), .shiftdr_is(shiftdr_is), .updatedr_is(updatedr_is),
        .tap_state(tap_state)
    );

    always #5 TCLK = ~TCLK;

    typedef struct {
        string      tag;
        int         sig;
        logic [3:0] val;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;

    function automatic logic [3:0] observe(input int sig);
        case (sig)
            0:  return tap_state;
            1:  return {2'b00, inst};
            2:  return {3'b000, TDO};
            3:  return {3'b000, TDO_EN};
            4:  return {3'b000, test_mode};
            5:  return {3'b000, clockdr};
            6:  return {3'b000, shiftdr};
            7:  return {3'b000, updatedr};
            8:  return {3'b000, clockdr_is};
            9:  return {3'b000, shiftdr_is};
            10: return {3'b000, updatedr_is};
            default: return 4'hx;
        endcase
    endfunction

    task automatic expect_sig(input string tag, input int sig, input logic [3:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        q.push_back(e);
    endtask

    task automatic expect_en(input string tag, input logic [5:0] en);
        expect_sig({tag, ".clockdr"},     5,  {3'b000, en[5]});
        expect_sig({tag, ".shiftdr"},     6,  {3'b000, en[4]});
        expect_sig({tag, ".updatedr"},    7,  {3'b000, en[3]});
        expect_sig({tag, ".clockdr_is"},  8,  {3'b000, en[2]});
        expect_sig({tag, ".shiftdr_is"},  9,  {3'b000, en[1]});
        expect_sig({tag, ".updatedr_is"}, 10, {3'b000, en[0]});
    endtask

    task automatic check_queue();
        exp_t       e;
        logic [3:0] obs;
        while (q.size() > 0) begin
            e   = q.pop_front();
            obs = observe(e.sig);
            vectors++;
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    // Drive inputs, take one rising edge, then compare queued expectations.
    task automatic step(input logic trst, input logic tms, input logic tdi);
        TRST = trst;
        TMS  = tms;
        TDI  = tdi;
        @(posedge TCLK);
        #1;
        check_queue();
    endtask

    task automatic step_state(input string tag, input logic tms, input logic tdi, input logic [3:0] st);
        expect_sig({tag, ".state"}, 0, st);
        step(1'b0, tms, tdi);
    endtask

    logic [8:0] walk_tms;
    logic [3:0] walk_st [9];
    logic [3:0] isr_pat;
    logic [3:0] byp_tdi;
    logic [3:0] byp_tdo;

    initial begin
        #2;
        // Reset
        for (int i = 0; i < 2; i++) begin
            expect_sig("rst.state", 0, 4'd0);
            expect_sig("rst.inst", 1, 4'd2);
            expect_sig("rst.tdo", 2, 4'd0);
            expect_sig("rst.tdo_en", 3, 4'd0);
            expect_en("rst", 6'b000000);
            step(1'b1, 1'b0, 1'b0);
        end
        expect_sig("rel.inst", 1, 4'd2);
        expect_en("rel", 6'b000000);
        step_state("rel", 1'b0, 1'b0, 4'd1);

        // Five TMS=1 from RTI reach TLR
        step_state("tlr5", 1'b1, 1'b0, 4'd2);
        step_state("tlr5", 1'b1, 1'b0, 4'd9);
        step_state("tlr5", 1'b1, 1'b0, 4'd0);
        step_state("tlr5", 1'b1, 1'b0, 4'd0);
        step_state("tlr5", 1'b1, 1'b0, 4'd0);

        // DR-side state walk from TLR
        walk_tms = 9'b011010010;  // bit 0 applied first: 0,1,0,0,1,0,1,1,0
        walk_st  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd1};
        for (int i = 0; i < 9; i++) begin
            if (walk_st[i] == 4'd4) begin
                expect_sig("walk.tdo_en", 3, 4'd1);
                expect_en("walk.byp", 6'b000000);
            end
            step_state("walk", walk_tms[i], 1'b0, walk_st[i]);
        end
        step_state("ir_walk", 1'b1, 1'b0, 4'd2);
        step_state("ir_walk", 1'b1, 1'b0, 4'd9);
        step_state("ir_walk", 1'b0, 1'b0, 4'd10);
        step_state("ir_walk", 1'b0, 1'b0, 4'd11);
        step_state("shir5", 1'b1, 1'b0, 4'd12);
        step_state("shir5", 1'b1, 1'b0, 4'd15);
        step_state("shir5", 1'b1, 1'b0, 4'd2);
        step_state("shir5", 1'b1, 1'b0, 4'd9);
        step_state("shir5", 1'b1, 1'b0, 4'd0);
        step_state("shir5", 1'b0, 1'b0, 4'd1);

        // IR load INTSCAN: captured 01 shifts out LSB first
        step_state("ir11", 1'b1, 1'b0, 4'd2);
        step_state("ir11", 1'b1, 1'b0, 4'd9);
        step_state("ir11", 1'b0, 1'b0, 4'd10);
        expect_sig("ir11.tdo0", 2, 4'd1);
        expect_sig("ir11.tdo_en", 3, 4'd1);
        step_state("ir11", 1'b0, 1'b0, 4'd11);
        expect_sig("ir11.tdo1", 2, 4'd0);
        step_state("ir11", 1'b0, 1'b1, 4'd11);
        expect_sig("ir11.inst_ex1", 1, 4'd2);
        step_state("ir11", 1'b1, 1'b1, 4'd12);
        expect_sig("ir11.inst_upd", 1, 4'd2);
        step_state("ir11", 1'b1, 1'b0, 4'd15);
        expect_sig("ir11.inst", 1, 4'd3);
        expect_sig("ir11.test_mode", 4, 4'd1);
        step_state("ir11", 1'b0, 1'b0, 4'd1);

        // INTSCAN DR scan
        step_state("isr", 1'b1, 1'b0, 4'd2);
        expect_en("isr.cap", 6'b000100);
        step_state("isr", 1'b0, 1'b0, 4'd3);
        isr_pat = 4'b0110;
        for (int i = 0; i < 8; i++) begin
            TDO_ISR = isr_pat[i % 4] ^ (i >= 4);
            TDO_BSR = ~TDO_ISR;
            expect_en("isr.sh", 6'b000110);
            expect_sig("isr.tdo", 2, {3'b000, TDO_ISR});
            step_state("isr", 1'b0, 1'b0, 4'd4);
        end
        expect_en("isr.ex1", 6'b000000);
        step_state("isr", 1'b1, 1'b0, 4'd5);
        expect_en("isr.upd", 6'b000001);
        step_state("isr", 1'b1, 1'b0, 4'd8);
        expect_en("isr.rti", 6'b000000);
        step_state("isr", 1'b0, 1'b0, 4'd1);

        // TLR reloads BYPASS
        step_state("tlr", 1'b1, 1'b0, 4'd2);
        step_state("tlr", 1'b1, 1'b0, 4'd9);
        step_state("tlr", 1'b1, 1'b0, 4'd0);
        expect_sig("tlr.inst", 1, 4'd2);
        expect_sig("tlr.test_mode", 4, 4'd0);
        step_state("tlr", 1'b1, 1'b0, 4'd0);
        step_state("tlr", 1'b0, 1'b0, 4'd1);

        // Explicit BYPASS load (shift in 0 then 1 -> 10)
        step_state("ir10", 1'b1, 1'b0, 4'd2);
        step_state("ir10", 1'b1, 1'b0, 4'd9);
        step_state("ir10", 1'b0, 1'b0, 4'd10);
        step_state("ir10", 1'b0, 1'b0, 4'd11);
        step_state("ir10", 1'b0, 1'b0, 4'd11);
        step_state("ir10", 1'b1, 1'b1, 4'd12);
        step_state("ir10", 1'b1, 1'b0, 4'd15);
        expect_sig("ir10.inst", 1, 4'd2);
        step_state("ir10", 1'b0, 1'b0, 4'd1);

        // BYPASS DR scan: one-cycle delay with leading 0
        TDO_BSR = 1'b1;
        TDO_ISR = 1'b1;
        step_state("byp", 1'b1, 1'b0, 4'd2);
        expect_en("byp.cap", 6'b000000);
        step_state("byp", 1'b0, 1'b0, 4'd3);
        byp_tdi = 4'b1101;  // bit 0 first: 1,0,1,1
        byp_tdo = 4'b1010;  // bit 0 first: 0,1,0,1
        expect_sig("byp.tdo0", 2, {3'b000, byp_tdo[0]});
        expect_en("byp.sh", 6'b000000);
        step_state("byp", 1'b0, 1'b0, 4'd4);
        for (int i = 0; i < 3; i++) begin
            expect_sig("byp.tdo", 2, {3'b000, byp_tdo[i + 1]});
            expect_en("byp.sh", 6'b000000);
            step_state("byp", 1'b0, byp_tdi[i], 4'd4);
        end
        step_state("byp", 1'b1, byp_tdi[3], 4'd5);
        expect_en("byp.upd", 6'b000000);
        step_state("byp", 1'b1, 1'b0, 4'd8);
        step_state("byp", 1'b0, 1'b0, 4'd1);

        // EXTEST load (00) then TRST abort mid-shift
        step_state("ir00", 1'b1, 1'b0, 4'd2);
        step_state("ir00", 1'b1, 1'b0, 4'd9);
        step_state("ir00", 1'b0, 1'b0, 4'd10);
        step_state("ir00", 1'b0, 1'b0, 4'd11);
        step_state("ir00", 1'b0, 1'b0, 4'd11);
        step_state("ir00", 1'b1, 1'b0, 4'd12);
        step_state("ir00", 1'b1, 1'b0, 4'd15);
        expect_sig("ir00.inst", 1, 4'd0);
        expect_sig("ir00.test_mode", 4, 4'd1);
        step_state("ir00", 1'b0, 1'b0, 4'd1);
        step_state("ext", 1'b1, 1'b0, 4'd2);
        expect_en("ext.cap", 6'b100000);
        step_state("ext", 1'b0, 1'b0, 4'd3);
        TDO_BSR = 1'b0;
        TDO_ISR = 1'b1;
        expect_en("ext.sh", 6'b110000);
        expect_sig("ext.tdo", 2, 4'd0);
        step_state("ext", 1'b0, 1'b1, 4'd4);
        expect_sig("abort.state", 0, 4'd0);
        expect_en("abort", 6'b000000);
        expect_sig("abort.inst", 1, 4'd2);
        expect_sig("abort.test_mode", 4, 4'd0);
        expect_sig("abort.tdo", 2, 4'd0);
        step(1'b1, 1'b0, 1'b0);
        expect_en("post", 6'b000000);
        step_state("post", 1'b1, 1'b0, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
